cpu_host_ctrl: RTL and testbench

CPU_HOST_CTRL -- requirements
Module: cpu_host_ctrl

---
 rtl/cpu_host_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_host_ctrl.sv | 612 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_ctrl.sv
// cpu_host_ctrl: host-side sequencer around a CPU run.
// A run preloads a byte stream into data memory and raises req for the CPU.
// It waits for a fresh done level, with a timeout, then streams back a
// window of data memory and pulses complete.
module cpu_host_ctrl #(
    parameter int AW = 8,
    parameter int TW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW-1:0] ld_len,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_len,
    input  logic          src_valid,
    input  logic [7:0]    src_data,
    output logic          src_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          req,
    input  logic          done,
    output logic          res_valid,
    output logic [7:0]    res_data,
    input  logic          res_ready,
    output logic          busy,
    output logic          complete,
    output logic [1:0]    status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RD_ADDR,
        S_RD_DATA,
        S_RD_OUT,
        S_FINISH
    } state_t;

    // The timer is tested on the cycle it increments, so seeing 2^TW-2
    // means this WAIT cycle is the (2^TW-1)th one.
    localparam logic [TW-1:0] TIMER_PRE = {{(TW-1){1'b1}}, 1'b0};

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

    state_t        r_state;
    state_t        w_nextState;

    logic [AW-1:0] r_ldBase;
    logic [AW-1:0] r_ldLen;
    logic [AW-1:0] r_rdBase;
    logic [AW-1:0] r_rdLen;
    logic [AW-1:0] r_cnt;
    logic [TW-1:0] r_timer;
    logic          r_armed;
    logic          r_req;
    logic [1:0]    r_status;
    logic [7:0]    r_resData;

    logic          w_srcFire;
    logic          w_resFire;
    logic          w_ldLast;
    logic          w_rdLast;
    logic          w_doneAccept;
    logic          w_timeout;

    assign w_srcFire    = (r_state == S_LOAD) && src_valid;
    assign w_resFire    = (r_state == S_RD_OUT) && res_ready;
    assign w_ldLast     = (r_cnt == r_ldLen - AW'(1));
    assign w_rdLast     = (r_cnt == r_rdLen - AW'(1));
    assign w_doneAccept = (r_state == S_WAIT) && r_armed && done;
    assign w_timeout    = (r_state == S_WAIT) && (r_timer == TIMER_PRE);

    assign req      = r_req;
    assign status   = r_status;
    assign res_data = r_resData;

    // State register; reset abandons any run in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection; an accepted done takes priority over timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (ld_len != '0) ? S_LOAD : S_WAIT;
                end
            end
            S_LOAD: begin
                if (w_srcFire && w_ldLast) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_doneAccept) begin
                    w_nextState = (r_rdLen != '0) ? S_RD_ADDR : S_FINISH;
                end else if (w_timeout) begin
                    w_nextState = S_FINISH;
                end
            end
            S_RD_ADDR: w_nextState = S_RD_DATA;
            S_RD_DATA: w_nextState = S_RD_OUT;
            S_RD_OUT: begin
                if (w_resFire) begin
                    w_nextState = w_rdLast ? S_FINISH : S_RD_ADDR;
                end
            end
            S_FINISH: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // Per-state outputs; everything idles at zero so reset shows clean values.
    always_comb begin
        src_ready = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        res_valid = 1'b0;
        busy      = 1'b1;
        complete  = 1'b0;
        case (r_state)
            S_IDLE: busy = 1'b0;
            S_LOAD: begin
                src_ready = 1'b1;
                mem_addr  = r_ldBase + r_cnt;
                if (src_valid) begin
                    mem_wr_en = 1'b1;
                    mem_wdata = src_data;
                end
            end
            S_RD_ADDR: mem_addr  = r_rdBase + r_cnt;
            S_RD_OUT:  res_valid = 1'b1;
            S_FINISH:  complete  = 1'b1;
            default: ;
        endcase
    end

    // req is a registered copy of "next state is WAIT" so it is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req <= 1'b0;
        end else begin
            r_req <= (w_nextState == S_WAIT);
        end
    end

    // Run parameters, byte counter, timer, arming and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ldBase  <= '0;
            r_ldLen   <= '0;
            r_rdBase  <= '0;
            r_rdLen   <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_armed   <= 1'b0;
            r_status  <= STATUS_OK;
            r_resData <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ldBase <= ld_base;
                        r_ldLen  <= ld_len;
                        r_rdBase <= rd_base;
                        r_rdLen  <= rd_len;
                        r_cnt    <= '0;
                        r_timer  <= '0;
                        r_armed  <= 1'b0;
                        r_status <= STATUS_OK;
                    end
                end
                S_LOAD: begin
                    if (w_srcFire) begin
                        if (w_ldLast) begin
                            r_cnt   <= '0;
                            r_timer <= '0;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + TW'(1);
                    if (!done) begin
                        r_armed <= 1'b1;
                    end
                    if (w_timeout && !w_doneAccept) begin
                        r_status <= STATUS_TIMEOUT;
                    end
                end
                S_RD_DATA: r_resData <= mem_rdata;
                S_RD_OUT: begin
                    if (w_resFire) begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Testbench for cpu_host_ctrl: scenario tasks with randomized runs checked
// against a byte-level model of memory, preload writes and readback stream.
module tb_cpu_host_ctrl;

    localparam int AW = 8;
    localparam int TW = 4;
    localparam int TIMEOUT_CYCLES = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] ld_base, ld_len, rd_base, rd_len;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          req;
    logic          done;
    logic          res_valid;
    logic [7:0]    res_data;
    logic          res_ready;
    logic          busy;
    logic          complete;
    logic [1:0]    status;

    int checks = 0;
    int errors = 0;

    logic [7:0] tbMem  [256];
    logic [7:0] refMem [256];
    logic [7:0] srcBytes [16];

    logic [7:0] expWrAddr[$];
    logic [7:0] expWrData[$];
    logic [7:0] expRd[$];

    logic [7:0] wrAddrQ[$];
    logic [7:0] wrDataQ[$];
    logic [7:0] rdQ[$];
    int completeCount;
    int reqCycles;
    int resValidCycles;

    cpu_host_ctrl #(.AW(AW), .TW(TW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_base(ld_base), .ld_len(ld_len), .rd_base(rd_base), .rd_len(rd_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .req(req), .done(done),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .complete(complete), .status(status)
    );

    always #5 clk = ~clk;

    // Data memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        mem_rdata <= tbMem[mem_addr];
        if (mem_wr_en) tbMem[mem_addr] = mem_wdata;
    end

    // Observe the DUT mid-cycle: writes, accepted results, pulses, req time.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            wrAddrQ.push_back(mem_addr);
            wrDataQ.push_back(mem_wdata);
        end
        if (res_valid && res_ready) rdQ.push_back(res_data);
        if (complete) completeCount++;
        if (req) reqCycles++;
        if (res_valid) resValidCycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearMonitor();
        wrAddrQ.delete();
        wrDataQ.delete();
        rdQ.delete();
        completeCount = 0;
        reqCycles = 0;
        resValidCycles = 0;
    endtask

    // Reference model: apply the preload to memory, then read the window.
    task automatic modelRun(input logic [7:0] lb, input logic [7:0] ll,
                            input logic [7:0] rb, input logic [7:0] rl);
        logic [7:0] a;
        expWrAddr.delete();
        expWrData.delete();
        expRd.delete();
        for (int i = 0; i < int'(ll); i++) begin
            a = lb + 8'(i);
            refMem[a] = srcBytes[i];
            expWrAddr.push_back(a);
            expWrData.push_back(srcBytes[i]);
        end
        for (int i = 0; i < int'(rl); i++) begin
            a = rb + 8'(i);
            expRd.push_back(refMem[a]);
        end
    endtask

    task automatic fillBytes();
        for (int i = 0; i < 16; i++) srcBytes[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic startRun(input logic [7:0] lb, input logic [7:0] ll,
                            input logic [7:0] rb, input logic [7:0] rl);
        ld_base = lb;
        ld_len  = ll;
        rd_base = rb;
        rd_len  = rl;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // stallMode 0: always valid, 1: random gaps, 2: a single gap after byte 0.
    task automatic driveLoad(input int len, input int stallMode, output bit ok);
        int idx;
        int guard;
        bit hs;
        idx = 0;
        guard = 0;
        while (idx < len && guard < 200) begin
            case (stallMode)
                0:       src_valid = 1'b1;
                1:       src_valid = ($urandom_range(0, 2) != 0);
                default: src_valid = (guard != 1);
            endcase
            src_data = srcBytes[idx];
            @(negedge clk);
            hs = src_valid && src_ready;
            tick();
            if (hs) idx++;
            guard++;
        end
        src_valid = 1'b0;
        src_data  = 8'h00;
        ok = (idx == len);
    endtask

    task automatic driveReadback(input int mode, output bit saw);
        int guard;
        guard = 0;
        saw = 1'b0;
        while (!saw && guard < 400) begin
            res_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (complete) saw = 1'b1;
            tick();
            guard++;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        reset = 1'b0;
        start = 1'b1;
        #3;
        obs = {req, mem_wr_en, src_ready, res_valid, busy, complete, status,
               res_data, mem_addr, mem_wdata};
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 32'h0);
        end
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_example();
        bit ok, saw;
        logic [7:0] wantAddr[3];
        logic [7:0] wantData[3];
        logic [7:0] wantRd[2];
        wantAddr = '{8'h10, 8'h11, 8'h12};
        wantData = '{8'hA1, 8'hB2, 8'hC3};
        wantRd   = '{8'h5A, 8'h6B};
        tbMem[8'h40] = 8'h5A; refMem[8'h40] = 8'h5A;
        tbMem[8'h41] = 8'h6B; refMem[8'h41] = 8'h6B;
        srcBytes[0] = 8'hA1; srcBytes[1] = 8'hB2; srcBytes[2] = 8'hC3;
        modelRun(8'h10, 8'd3, 8'h40, 8'd2);
        clearMonitor();
        done = 1'b0;
        startRun(8'h10, 8'd3, 8'h40, 8'd2);
        driveLoad(3, 2, ok);
        repeat (5) tick();
        done = 1'b1;
        driveReadback(0, saw);
        checks++;
        if (!(ok && saw)) begin
            errors++;
            $display("FAIL example_progress got=%b%b want=11", ok, saw);
        end
        checks++;
        if (wrAddrQ.size() != 3) begin
            errors++;
            $display("FAIL example_write_count got=%0d want=3", wrAddrQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({wrAddrQ[i], wrDataQ[i]} !== {wantAddr[i], wantData[i]}) begin
                    errors++;
                    $display("FAIL example_write%0d got=%h:%h want=%h:%h", i,
                             wrAddrQ[i], wrDataQ[i], wantAddr[i], wantData[i]);
                end
            end
        end
        checks++;
        if (rdQ.size() != 2) begin
            errors++;
            $display("FAIL example_stream_len got=%0d want=2", rdQ.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rdQ[i] !== wantRd[i]) begin
                    errors++;
                    $display("FAIL example_stream%0d got=%h want=%h", i, rdQ[i], wantRd[i]);
                end
            end
        end
        checks++;
        if ({reqCycles, completeCount} != {32'd6, 32'd1}) begin
            errors++;
            $display("FAIL example_req_complete got=%0d,%0d want=6,1", reqCycles, completeCount);
        end
        checks++;
        if ({status, busy} !== 3'b000) begin
            errors++;
            $display("FAIL example_status_busy got=%b,%b want=00,0", status, busy);
        end
    endtask

    task automatic test_wrap();
        bit ok, saw;
        logic [7:0] wantAddr[4];
        wantAddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        fillBytes();
        modelRun(8'hFE, 8'd4, 8'hFE, 8'd4);
        clearMonitor();
        done = 1'b0;
        startRun(8'hFE, 8'd4, 8'hFE, 8'd4);
        driveLoad(4, 1, ok);
        repeat ($urandom_range(1, 10)) tick();
        done = 1'b1;
        driveReadback(1, saw);
        checks++;
        if (wrAddrQ.size() != 4 || !ok || !saw) begin
            errors++;
            $display("FAIL wrap_write_count got=%0d want=4", wrAddrQ.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({wrAddrQ[i], wrDataQ[i]} !== {wantAddr[i], srcBytes[i]}) begin
                    errors++;
                    $display("FAIL wrap_write%0d got=%h:%h want=%h:%h", i,
                             wrAddrQ[i], wrDataQ[i], wantAddr[i], srcBytes[i]);
                end
            end
        end
        checks++;
        if (rdQ.size() != 4) begin
            errors++;
            $display("FAIL wrap_stream_len got=%0d want=4", rdQ.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rdQ[i] !== srcBytes[i]) begin
                    errors++;
                    $display("FAIL wrap_stream%0d got=%h want=%h", i, rdQ[i], srcBytes[i]);
                end
            end
        end
    endtask

    task automatic test_leftover();
        bit ok, saw;
        logic [7:0] lb, rb;
        fillBytes();
        lb = 8'($urandom_range(0, 255));
        rb = lb;
        modelRun(lb, 8'd2, rb, 8'd2);
        clearMonitor();
        done = 1'b1;
        startRun(lb, 8'd2, rb, 8'd2);
        driveLoad(2, 0, ok);
        repeat (2) tick();
        done = 1'b0;
        repeat (3) tick();
        checks++;
        if ({resValidCycles, reqCycles} != {32'd0, 32'd5} || !busy) begin
            errors++;
            $display("FAIL leftover_no_early_readback got=%0d,%0d want=0,5",
                     resValidCycles, reqCycles);
        end
        done = 1'b1;
        driveReadback(1, saw);
        checks++;
        if (reqCycles != 6 || !saw || !ok) begin
            errors++;
            $display("FAIL leftover_wait_len got=%0d want=6", reqCycles);
        end
        checks++;
        if (rdQ.size() != 2) begin
            errors++;
            $display("FAIL leftover_stream_len got=%0d want=2", rdQ.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (rdQ[i] !== expRd[i]) begin
                    errors++;
                    $display("FAIL leftover_stream%0d got=%h want=%h", i, rdQ[i], expRd[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok, saw;
        logic [7:0] lb;
        fillBytes();
        lb = 8'($urandom_range(0, 255));
        modelRun(lb, 8'd1, 8'h20, 8'd3);
        clearMonitor();
        done = 1'b0;
        startRun(lb, 8'd1, 8'h20, 8'd3);
        driveLoad(1, 0, ok);
        driveReadback(0, saw);
        checks++;
        if (reqCycles != TIMEOUT_CYCLES || !ok || !saw) begin
            errors++;
            $display("FAIL timeout_wait_len got=%0d want=%0d", reqCycles, TIMEOUT_CYCLES);
        end
        checks++;
        if (status !== 2'b01) begin
            errors++;
            $display("FAIL timeout_status got=%b want=01", status);
        end
        checks++;
        if (resValidCycles != 0 || rdQ.size() != 0 || completeCount != 1) begin
            errors++;
            $display("FAIL timeout_no_readback got=%0d,%0d want=0,1",
                     resValidCycles, completeCount);
        end
        repeat (3) tick();
        checks++;
        if (status !== 2'b01) begin
            errors++;
            $display("FAIL timeout_status_hold got=%b want=01", status);
        end
        clearMonitor();
        startRun(8'h00, 8'd0, 8'h00, 8'd0);
        checks++;
        if (status !== 2'b00) begin
            errors++;
            $display("FAIL timeout_status_clear got=%b want=00", status);
        end
        tick();
        done = 1'b1;
        driveReadback(0, saw);
        checks++;
        if (!saw || completeCount != 1 || status !== 2'b00) begin
            errors++;
            $display("FAIL empty_run got=%0d,%b want=1,00", completeCount, status);
        end
    endtask

    task automatic test_backpressure();
        bit saw, found;
        logic [7:0] rb;
        logic [7:0] holdAddr;
        rb = 8'($urandom_range(0, 255));
        modelRun(8'h00, 8'd0, rb, 8'd3);
        clearMonitor();
        done = 1'b0;
        res_ready = 1'b0;
        startRun(8'h00, 8'd0, rb, 8'd3);
        repeat (2) tick();
        done = 1'b1;
        found = 1'b0;
        for (int g = 0; g < 20 && !found; g++) begin
            @(negedge clk);
            if (res_valid) found = 1'b1;
            else tick();
        end
        holdAddr = mem_addr;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({res_valid, res_data, mem_addr} !== {1'b1, expRd[0], holdAddr}) begin
                errors++;
                $display("FAIL stall_hold%0d got=%b,%h,%h want=1,%h,%h", k,
                         res_valid, res_data, mem_addr, expRd[0], holdAddr);
            end
            tick();
            if (k < 9) @(negedge clk);
        end
        driveReadback(1, saw);
        checks++;
        if (rdQ.size() != 3 || !saw) begin
            errors++;
            $display("FAIL stall_stream_len got=%0d want=3", rdQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rdQ[i] !== expRd[i]) begin
                    errors++;
                    $display("FAIL stall_stream%0d got=%h want=%h", i, rdQ[i], expRd[i]);
                end
            end
        end
    endtask

    task automatic test_start_busy();
        bit ok, saw;
        logic [7:0] lb, rb;
        fillBytes();
        lb = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        modelRun(lb, 8'd3, rb, 8'd2);
        clearMonitor();
        done = 1'b0;
        startRun(lb, 8'd3, rb, 8'd2);
        start   = 1'b1;
        ld_base = ~lb;
        ld_len  = 8'd5;
        rd_len  = 8'd0;
        driveLoad(3, 1, ok);
        repeat (3) tick();
        start = 1'b0;
        done  = 1'b1;
        driveReadback(1, saw);
        repeat (2) tick();
        checks++;
        if (wrAddrQ.size() != 3 || !ok || !saw) begin
            errors++;
            $display("FAIL busy_start_writes got=%0d want=3", wrAddrQ.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({wrAddrQ[i], wrDataQ[i]} !== {expWrAddr[i], expWrData[i]}) begin
                    errors++;
                    $display("FAIL busy_start_write%0d got=%h:%h want=%h:%h", i,
                             wrAddrQ[i], wrDataQ[i], expWrAddr[i], expWrData[i]);
                end
            end
        end
        checks++;
        if (rdQ.size() != 2 || rdQ[0] !== expRd[0] || rdQ[1] !== expRd[1]) begin
            errors++;
            $display("FAIL busy_start_stream got=%0d bytes want=2 (%h %h)",
                     rdQ.size(), expRd[0], expRd[1]);
        end
        checks++;
        if (reqCycles != 4 || completeCount != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_no_restart got=%0d,%0d,%b want=4,1,0",
                     reqCycles, completeCount, busy);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] lb;
        logic [31:0] obs;
        fillBytes();
        lb = 8'($urandom_range(0, 255));
        clearMonitor();
        done = 1'b0;
        startRun(lb, 8'd3, 8'h00, 8'd1);
        src_valid = 1'b1;
        src_data  = srcBytes[0];
        tick();
        src_data = srcBytes[1];
        #1;
        reset = 1'b0;
        start = 1'b1;
        #1;
        obs = {req, mem_wr_en, src_ready, res_valid, busy, complete, status,
               res_data, mem_addr, mem_wdata};
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got=%h want=%h", obs, 32'h0);
        end
        @(negedge clk);
        obs = {req, mem_wr_en, src_ready, res_valid, busy, complete, status,
               res_data, mem_addr, mem_wdata};
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset_hold got=%h want=%h", obs, 32'h0);
        end
        tick();
        start = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || src_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle_after got=%b,%b want=0,0", busy, src_ready);
        end
        checks++;
        if (wrAddrQ.size() != 1 || wrAddrQ[0] !== lb || wrDataQ[0] !== srcBytes[0]) begin
            errors++;
            $display("FAIL midrun_writes got=%0d want=1 at %h", wrAddrQ.size(), lb);
        end
        src_valid = 1'b0;
        refMem[lb] = srcBytes[0];
    endtask

    task automatic test_random();
        bit ok, saw;
        logic [7:0] lb, ll, rb, rl;
        int d;
        for (int iter = 0; iter < 8; iter++) begin
            fillBytes();
            lb = 8'($urandom_range(0, 255));
            ll = 8'($urandom_range(0, 8));
            rb = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(0, 6));
            d  = (iter == 0) ? TIMEOUT_CYCLES - 1 : $urandom_range(1, TIMEOUT_CYCLES - 2);
            modelRun(lb, ll, rb, rl);
            clearMonitor();
            done = 1'b0;
            startRun(lb, ll, rb, rl);
            driveLoad(int'(ll), 1, ok);
            repeat (d) tick();
            done = 1'b1;
            driveReadback(1, saw);
            checks++;
            if (wrAddrQ.size() != expWrAddr.size() || !ok || !saw) begin
                errors++;
                $display("FAIL rand%0d_write_count got=%0d want=%0d", iter,
                         wrAddrQ.size(), expWrAddr.size());
            end else begin
                for (int i = 0; i < expWrAddr.size(); i++) begin
                    checks++;
                    if ({wrAddrQ[i], wrDataQ[i]} !== {expWrAddr[i], expWrData[i]}) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d got=%h:%h want=%h:%h", iter, i,
                                 wrAddrQ[i], wrDataQ[i], expWrAddr[i], expWrData[i]);
                    end
                end
            end
            checks++;
            if (rdQ.size() != expRd.size()) begin
                errors++;
                $display("FAIL rand%0d_stream_len got=%0d want=%0d", iter,
                         rdQ.size(), expRd.size());
            end else begin
                for (int i = 0; i < expRd.size(); i++) begin
                    checks++;
                    if (rdQ[i] !== expRd[i]) begin
                        errors++;
                        $display("FAIL rand%0d_stream%0d got=%h want=%h", iter, i,
                                 rdQ[i], expRd[i]);
                    end
                end
            end
            checks++;
            if (reqCycles != d + 1 || completeCount != 1 || status !== 2'b00) begin
                errors++;
                $display("FAIL rand%0d_wait_status got=%0d,%0d,%b want=%0d,1,00", iter,
                         reqCycles, completeCount, status, d + 1);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; done = 1'b0;
        ld_base = '0; ld_len = '0; rd_base = '0; rd_len = '0;
        src_valid = 1'b0; src_data = '0; res_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tbMem[i]  = 8'($urandom_range(0, 255));
            refMem[i] = tbMem[i];
        end
        clearMonitor();
        test_reset();
        test_example();
        test_wrap();
        test_leftover();
        test_timeout();
        test_backpressure();
        test_start_busy();
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
